// File: rtl/flash_loader_pkg.sv
// Shared types and constants for the boot-time SPI flash to ramio copier.
// Holds the controller state encoding, the flash read command, the ramio write
// type for a full word, the SPI run lengths and a byte-lane insertion helper.
package flash_loader_pkg;

   typedef enum logic [2:0] {
      WaitReady,
      Startup,
      SendCmd,
      SendAddr,
      ReadData,
      StartWrite,
      Write,
      Done
   } state_e;

   localparam logic [7:0] FlashCmdRead  = 8'h03;
   localparam logic [1:0] WriteTypeWord = 2'b11;

   // SPI run lengths, expressed as (bit count - 1) so that 32 fits in 5 bits.
   localparam logic [4:0] CmdBitsM1  = 5'd7;
   localparam logic [4:0] AddrBitsM1 = 5'd23;
   localparam logic [4:0] ByteBitsM1 = 5'd7;

   // Replace byte lane idx of word with b (lane 0 = bits 7:0, little-endian).
   function automatic logic [31:0] place_byte(input logic [31:0] word,
                                              input logic [1:0]  idx,
                                              input logic [7:0]  b);
      logic [31:0] r;
      r = word;
      r[{idx, 3'b000} +: 8] = b;
      return r;
   endfunction

endpackage

// File: rtl/flash_loader_if.sv
// ramio request port as seen by the loader.
//   enable      request strobe, held until busy=0 is observed
//   write_type  2'b11 for a word write, 0 when idle
//   read_type   always 0 from the loader
//   address     byte address of the word
//   data_in     word to write
//   busy        ramio cannot accept a request this cycle
// master = the loader (drives the request), slave = ramio (drives busy).
interface flash_loader_if;

   logic        enable;
   logic [1:0]  write_type;
   logic [2:0]  read_type;
   logic [31:0] address;
   logic [31:0] data_in;
   logic        busy;

   modport master (
      output enable, write_type, read_type, address, data_in,
      input  busy
   );

   modport slave (
      input  enable, write_type, read_type, address, data_in,
      output busy
   );

endinterface

// File: rtl/flash_spi_shifter.sv
// SPI mode-0 bit engine. A load starts a run of nbits+1 bits taken MSB first
// from tx_data[31:...]; every bit is two clk cycles: phase 0 (flash_clk low,
// mosi presents the bit) and phase 1 (flash_clk high). miso is taken at the
// end of phase 1. pause freezes the engine with the clock parked.
//   load/tx_data/nbits  start a run (nbits = bit count - 1)
//   pause               hold the current phase
//   busy                low when idle and also during the final cycle of a run,
//                       so a follow-on load can be chained without a gap
//   byte_out            last 8 bits received, including the bit on miso now;
//                       valid in the final cycle of a run
//   flash_clk/mosi/miso SPI pins
module flash_spi_shifter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [31:0] tx_data,
   input  logic [4:0]  nbits,
   input  logic        pause,
   output logic        busy,
   output logic [7:0]  byte_out,
   output logic        flash_clk,
   output logic        flash_mosi,
   input  logic        flash_miso
);

   logic        active_q, active_d;
   logic        phase_q, phase_d;
   logic [4:0]  bit_cnt_q, bit_cnt_d;
   logic [31:0] sh_out_q, sh_out_d;
   logic [7:0]  sh_in_q, sh_in_d;
   logic        last;

   assign last       = active_q & phase_q & ~pause & (bit_cnt_q == 5'd0);
   assign busy       = active_q & ~last;
   assign byte_out   = {sh_in_q[6:0], flash_miso};
   assign flash_clk  = active_q & phase_q;
   assign flash_mosi = sh_out_q[31];

   // NOTE: every variable gets its hold value first so no path leaves it
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      active_d  = active_q;
      phase_d   = phase_q;
      bit_cnt_d = bit_cnt_q;
      sh_out_d  = sh_out_q;
      sh_in_d   = sh_in_q;
      if (load) begin
         active_d  = 1'b1;
         phase_d   = 1'b0;
         bit_cnt_d = nbits;
         sh_out_d  = tx_data;
      end else if (active_q && !pause) begin
         if (!phase_q) begin
            phase_d = 1'b1;
         end else begin
            // End of phase 1: take miso, move mosi on to the next bit.
            phase_d  = 1'b0;
            sh_in_d  = {sh_in_q[6:0], flash_miso};
            sh_out_d = {sh_out_q[30:0], 1'b0};
            if (bit_cnt_q == 5'd0) begin
               active_d = 1'b0;
            end else begin
               bit_cnt_d = bit_cnt_q - 5'd1;
            end
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the values from before the edge, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q  <= 1'b0;
         phase_q   <= 1'b0;
         bit_cnt_q <= 5'd0;
         sh_out_q  <= 32'd0;
         sh_in_q   <= 8'd0;
      end else begin
         active_q  <= active_d;
         phase_q   <= phase_d;
         bit_cnt_q <= bit_cnt_d;
         sh_out_q  <= sh_out_d;
         sh_in_q   <= sh_in_d;
      end
   end

endmodule

// File: rtl/flash_loader.sv
// Boot-time copier: after ram_ready and a startup delay, issues a flash read
// (0x03 + 24-bit address) and streams TransferByteCount bytes into ramio as
// little-endian 32-bit words. done is sticky; afterwards ramio belongs to the CPU.
//   clk, rst_n      clock, asynchronous active-low reset
//   ram_ready       SDRAM init complete, gates the start
//   flash_*         SPI flash pins
//   ramio           ramio request port (master side)
//   done            copy complete
module flash_loader
   import flash_loader_pkg::*;
#(
   parameter int unsigned StartupWaitCycles = 10,
   parameter logic [23:0] FlashStartAddress = 24'h000000,
   parameter logic [31:0] RamStartAddress   = 32'h0000_0000,
   parameter int unsigned TransferByteCount = 256
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ram_ready,
   output logic          flash_clk,
   output logic          flash_mosi,
   input  logic          flash_miso,
   output logic          flash_cs_n,
   flash_loader_if.master ramio,
   output logic          done
);

   localparam int ByteCntW    = (TransferByteCount < 4) ? 2 : $clog2(TransferByteCount + 1);
   localparam int StartupCntW = (StartupWaitCycles > 2) ? $clog2(StartupWaitCycles) : 1;
   localparam logic [ByteCntW-1:0] ByteTotal = ByteCntW'(TransferByteCount);

   state_e                 state_q, state_d;
   logic [StartupCntW-1:0] startup_cnt_q, startup_cnt_d;
   logic [ByteCntW-1:0]    byte_cnt_q, byte_cnt_d;
   logic [31:0]            word_q, word_d;
   logic [31:0]            addr_q, addr_d;
   logic                   cs_n_q, cs_n_d;
   logic                   done_q, done_d;
   logic                   enable_q, enable_d;
   logic [1:0]             write_type_q, write_type_d;
   logic [31:0]            address_q, address_d;
   logic [31:0]            data_q, data_d;

   logic        sh_load, sh_busy, sh_pause;
   logic [4:0]  sh_nbits;
   logic [31:0] sh_tx;
   logic [7:0]  sh_byte;

   // The flash read is only paused across a ramio write: cs_n stays low and
   // the next byte continues the same stream.
   assign sh_pause = (state_q == StartWrite) || (state_q == Write);

   flash_spi_shifter u_shifter (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (sh_load),
      .tx_data    (sh_tx),
      .nbits      (sh_nbits),
      .pause      (sh_pause),
      .busy       (sh_busy),
      .byte_out   (sh_byte),
      .flash_clk  (flash_clk),
      .flash_mosi (flash_mosi),
      .flash_miso (flash_miso)
   );

   assign flash_cs_n       = cs_n_q;
   assign done             = done_q;
   assign ramio.enable     = enable_q;
   assign ramio.write_type = write_type_q;
   assign ramio.read_type  = 3'd0;
   assign ramio.address    = address_q;
   assign ramio.data_in    = data_q;

   always_comb begin
      state_d       = state_q;
      startup_cnt_d = startup_cnt_q;
      byte_cnt_d    = byte_cnt_q;
      word_d        = word_q;
      addr_d        = addr_q;
      cs_n_d        = cs_n_q;
      done_d        = done_q;
      enable_d      = enable_q;
      write_type_d  = write_type_q;
      address_d     = address_q;
      data_d        = data_q;
      sh_load       = 1'b0;
      sh_nbits      = ByteBitsM1;
      sh_tx         = 32'd0;

      unique case (state_q)
         WaitReady: begin
            if (ram_ready) begin
               if (TransferByteCount == 0) begin
                  done_d  = 1'b1;
                  state_d = Done;
               end else begin
                  state_d = Startup;
               end
            end
         end
         Startup: begin
            if (32'(startup_cnt_q) + 32'd1 >= StartupWaitCycles) begin
               cs_n_d   = 1'b0;
               sh_load  = 1'b1;
               sh_nbits = CmdBitsM1;
               sh_tx    = {FlashCmdRead, 24'd0};
               state_d  = SendCmd;
            end else begin
               startup_cnt_d = startup_cnt_q + StartupCntW'(1);
            end
         end
         // In the shifting states the engine is always running, so busy=0
         // marks the final cycle of the current run.
         SendCmd: begin
            if (!sh_busy) begin
               sh_load  = 1'b1;
               sh_nbits = AddrBitsM1;
               sh_tx    = {FlashStartAddress, 8'd0};
               state_d  = SendAddr;
            end
         end
         SendAddr: begin
            if (!sh_busy) begin
               sh_load = 1'b1;
               state_d = ReadData;
            end
         end
         ReadData: begin
            if (!sh_busy) begin
               word_d     = place_byte(word_q, byte_cnt_q[1:0], sh_byte);
               byte_cnt_d = byte_cnt_q + ByteCntW'(1);
               if (byte_cnt_q[1:0] == 2'd3) begin
                  state_d = StartWrite;
               end else begin
                  sh_load = 1'b1;
               end
            end
         end
         StartWrite: begin
            if (!ramio.busy) begin
               enable_d     = 1'b1;
               write_type_d = WriteTypeWord;
               address_d    = addr_q;
               data_d       = word_q;
               state_d      = Write;
            end
         end
         Write: begin
            // The request is visible for at least this cycle and is held
            // until ramio reports not busy.
            if (!ramio.busy) begin
               enable_d     = 1'b0;
               write_type_d = 2'b00;
               address_d    = 32'd0;
               data_d       = 32'd0;
               addr_d       = addr_q + 32'd4;
               if (byte_cnt_q == ByteTotal) begin
                  cs_n_d  = 1'b1;
                  done_d  = 1'b1;
                  state_d = Done;
               end else begin
                  sh_load = 1'b1;
                  state_d = ReadData;
               end
            end
         end
         Done: begin
         end
         default: state_d = WaitReady;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= WaitReady;
         startup_cnt_q <= '0;
         byte_cnt_q    <= '0;
         word_q        <= 32'd0;
         addr_q        <= RamStartAddress;
         cs_n_q        <= 1'b1;
         done_q        <= 1'b0;
         enable_q      <= 1'b0;
         write_type_q  <= 2'b00;
         address_q     <= 32'd0;
         data_q        <= 32'd0;
      end else begin
         state_q       <= state_d;
         startup_cnt_q <= startup_cnt_d;
         byte_cnt_q    <= byte_cnt_d;
         word_q        <= word_d;
         addr_q        <= addr_d;
         cs_n_q        <= cs_n_d;
         done_q        <= done_d;
         enable_q      <= enable_d;
         write_type_q  <= write_type_d;
         address_q     <= address_d;
         data_q        <= data_d;
      end
   end

endmodule

// File: tb/tb_flash_loader.sv
// Bench for flash_loader: behavioural SPI flash (mode 0, read 0x03) holding
// random bytes, a ramio write logger with a small word memory, and scenario
// tasks comparing what was written against words assembled from flash content.
module tb_flash_loader;

   localparam int unsigned TbStartup = 10;
   localparam int unsigned TbBytes   = 256;
   localparam int unsigned TbWords   = TbBytes / 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ram_ready = 1'b0;
   logic flash_clk, flash_mosi, flash_cs_n, done;
   logic flash_miso = 1'b0;

   int tests = 0;
   int fails = 0;

   flash_loader_if ramio ();

   flash_loader #(
      .StartupWaitCycles (TbStartup),
      .FlashStartAddress (24'h000000),
      .RamStartAddress   (32'h0000_0000),
      .TransferByteCount (TbBytes)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ram_ready  (ram_ready),
      .flash_clk  (flash_clk),
      .flash_mosi (flash_mosi),
      .flash_miso (flash_miso),
      .flash_cs_n (flash_cs_n),
      .ramio      (ramio.master),
      .done       (done)
   );

   always #5 clk = ~clk;

   // ---------------- SPI flash model ----------------
   logic [7:0]  flash_mem [0:255];
   int          rise_cnt = 0;
   logic [31:0] cmd_addr_sr = 32'd0;
   int          fm_d;
   int unsigned fm_a;

   always @(negedge flash_cs_n) begin
      rise_cnt    = 0;
      cmd_addr_sr = 32'd0;
   end

   always @(posedge flash_clk) begin
      if (flash_cs_n == 1'b0) begin
         if (rise_cnt < 32) cmd_addr_sr = {cmd_addr_sr[30:0], flash_mosi};
         rise_cnt++;
      end
   end

   // Mode 0: after the 32 command/address bits the flash shifts a data bit
   // out on every falling clock edge.
   always @(negedge flash_clk) begin
      if (flash_cs_n == 1'b0 && rise_cnt >= 32) begin
         fm_d = rise_cnt - 32;
         fm_a = (32'(cmd_addr_sr[23:0]) + 32'(fm_d / 8)) % 256;
         flash_miso <= #1 flash_mem[fm_a][7 - (fm_d % 8)];
      end
   end

   // ---------------- ramio model ----------------
   logic [31:0] ram_mem [0:63];
   logic [31:0] log_addr [$];
   logic [31:0] log_data [$];
   logic [4:0]  log_types [$];
   bit          rand_busy_en = 1'b0;

   always @(posedge clk) begin
      if (rst_n && ramio.enable && !ramio.busy) begin
         log_addr.push_back(ramio.address);
         log_data.push_back(ramio.data_in);
         log_types.push_back({ramio.write_type, ramio.read_type});
         ram_mem[ramio.address[7:2]] = ramio.data_in;
      end
   end

   always @(negedge clk) begin
      if (rand_busy_en) ramio.busy = ($urandom_range(0, 3) == 0);
   end

   function automatic logic [31:0] flash_word(input int unsigned i);
      return {flash_mem[4*i+3], flash_mem[4*i+2], flash_mem[4*i+1], flash_mem[4*i]};
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [73:0] obs;
      rst_n = 1'b0;
      ram_ready = 1'b0;
      ramio.busy = 1'b0;
      #12;
      obs = {flash_cs_n, flash_clk, flash_mosi, ramio.enable, ramio.write_type,
             ramio.read_type, ramio.address, ramio.data_in, done};
      tests++;
      if (obs !== {1'b1, 73'd0}) begin
         fails++;
         $display("FAIL reset_values: got %h expected %h", obs, {1'b1, 73'd0});
      end
   endtask

   task automatic test_wait_ready();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         tests++;
         if ({flash_cs_n, ramio.enable} !== 2'b10) begin
            fails++;
            $display("FAIL wait_ready cycle %0d: cs_n=%b enable=%b expected cs_n=1 enable=0",
                     i, flash_cs_n, ramio.enable);
         end
      end
   endtask

   task automatic test_startup_delay();
      int n;
      ram_ready = 1'b1;
      @(posedge clk);
      for (n = 0; n < 50; n++) begin
         @(posedge clk);
         #1;
         if (flash_cs_n === 1'b0) break;
      end
      tests++;
      if (n + 1 != int'(TbStartup)) begin
         fails++;
         $display("FAIL startup_delay: cs_n fell after %0d cycles expected %0d", n + 1, TbStartup);
      end
   endtask

   task automatic test_cmd_addr();
      int n;
      for (n = 0; n < 300; n++) begin
         @(negedge clk);
         if (rise_cnt >= 32) break;
      end
      tests++;
      if (n == 300) begin
         fails++;
         $display("FAIL cmd_addr_timeout: %0d flash_clk rises expected 32", rise_cnt);
      end
      tests++;
      if (cmd_addr_sr !== 32'h0300_0000) begin
         fails++;
         $display("FAIL cmd_addr: got %h expected 03000000", cmd_addr_sr);
      end
   endtask

   task automatic test_busy_stall();
      int n;
      // Stall inside Write: the request must stay up and the SPI clock parked.
      for (n = 0; n < 2000; n++) begin
         @(negedge clk);
         if (log_addr.size() == 2 && ramio.enable === 1'b1) break;
      end
      tests++;
      if (n == 2000) begin
         fails++;
         $display("FAIL busy_stall_timeout: writes=%0d expected 2 then enable", log_addr.size());
      end
      ramio.busy = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         tests++;
         if ({ramio.enable, ramio.write_type, flash_clk} !== 4'b1110) begin
            fails++;
            $display("FAIL busy_stall_write cycle %0d: enable=%b write_type=%b flash_clk=%b expected 1 11 0",
                     i, ramio.enable, ramio.write_type, flash_clk);
         end
      end
      tests++;
      if (log_addr.size() != 2) begin
         fails++;
         $display("FAIL busy_stall_no_write: writes=%0d expected 2", log_addr.size());
      end
      ramio.busy = 1'b0;
      // Busy raised during ReadData: the loader must wait in StartWrite.
      for (n = 0; n < 200; n++) begin
         @(negedge clk);
         if (log_addr.size() == 3) break;
      end
      ramio.busy = 1'b1;
      repeat (100) @(negedge clk);
      tests++;
      if ({ramio.enable, flash_clk, 32'(log_addr.size())} !== {2'b00, 32'd3}) begin
         fails++;
         $display("FAIL busy_stall_startwrite: enable=%b flash_clk=%b writes=%0d expected 0 0 3",
                  ramio.enable, flash_clk, log_addr.size());
      end
      ramio.busy = 1'b0;
      rand_busy_en = 1'b1;
   endtask

   task automatic test_reset_mid_read();
      int n;
      logic [73:0] obs;
      for (n = 0; n < 5000; n++) begin
         @(negedge clk);
         if (log_addr.size() == 10 && flash_clk === 1'b1) break;
      end
      tests++;
      if (n == 5000) begin
         fails++;
         $display("FAIL mid_reset_timeout: writes=%0d expected 10", log_addr.size());
      end
      rand_busy_en = 1'b0;
      ramio.busy = 1'b0;
      for (int i = 0; i < 10 && i < log_addr.size(); i++) begin
         tests++;
         if ({log_addr[i], log_data[i]} !== {32'(4 * i), flash_word(i)}) begin
            fails++;
            $display("FAIL first_run_word %0d: addr=%h data=%h expected addr=%h data=%h",
                     i, log_addr[i], log_data[i], 4 * i, flash_word(i));
         end
      end
      #2;
      rst_n = 1'b0;
      #1;
      obs = {flash_cs_n, flash_clk, flash_mosi, ramio.enable, ramio.write_type,
             ramio.read_type, ramio.address, ramio.data_in, done};
      tests++;
      if (obs !== {1'b1, 73'd0}) begin
         fails++;
         $display("FAIL mid_reset_values: got %h expected %h", obs, {1'b1, 73'd0});
      end
      log_addr.delete();
      log_data.delete();
      log_types.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_full_run();
      int n;
      rand_busy_en = 1'b1;
      for (n = 0; n < 30000; n++) begin
         @(negedge clk);
         if (done === 1'b1) break;
      end
      rand_busy_en = 1'b0;
      ramio.busy = 1'b0;
      tests++;
      if (n == 30000) begin
         fails++;
         $display("FAIL full_run_timeout: done=%b writes=%0d", done, log_addr.size());
      end
      tests++;
      if (log_addr.size() != int'(TbWords)) begin
         fails++;
         $display("FAIL handshake_count: got %0d expected %0d", log_addr.size(), TbWords);
      end
      tests++;
      if (log_addr.size() > 0 && {log_addr[0], log_data[0]} !== {32'd0, flash_word(0)}) begin
         fails++;
         $display("FAIL restart_first_write: addr=%h data=%h expected 00000000 %h",
                  log_addr[0], log_data[0], flash_word(0));
      end
      for (int i = 0; i < log_addr.size() && i < int'(TbWords); i++) begin
         tests++;
         if ({log_addr[i], log_data[i], log_types[i]} !== {32'(4 * i), flash_word(i), 5'b11000}) begin
            fails++;
            $display("FAIL word %0d: addr=%h data=%h types=%b expected addr=%h data=%h types=11000",
                     i, log_addr[i], log_data[i], log_types[i], 4 * i, flash_word(i));
         end
      end
      tests++;
      if (log_addr.size() > 0 && log_addr[log_addr.size() - 1] !== 32'd252) begin
         fails++;
         $display("FAIL last_address: got %h expected 000000fc", log_addr[log_addr.size() - 1]);
      end
      tests++;
      if (log_addr.size() > 4 && {log_addr[4], log_data[4]} !== {32'd16, 32'hD5B8A9C4}) begin
         fails++;
         $display("FAIL offset16_write: addr=%h data=%h expected 00000010 d5b8a9c4",
                  log_addr[4], log_data[4]);
      end
      tests++;
      if (ram_mem[4] !== 32'hD5B8A9C4) begin
         fails++;
         $display("FAIL offset16_readback: got %h expected d5b8a9c4", ram_mem[4]);
      end
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         tests++;
         if ({flash_cs_n, done, ramio.enable, ramio.write_type} !== 5'b11000) begin
            fails++;
            $display("FAIL done_hold cycle %0d: cs_n=%b done=%b enable=%b write_type=%b expected 1 1 0 00",
                     i, flash_cs_n, done, ramio.enable, ramio.write_type);
         end
      end
      tests++;
      if (log_addr.size() != int'(TbWords)) begin
         fails++;
         $display("FAIL no_writes_after_done: got %0d expected %0d", log_addr.size(), TbWords);
      end
   endtask

   initial begin
      ramio.busy = 1'b0;
      for (int i = 0; i < 256; i++) flash_mem[i] = 8'($urandom);
      flash_mem[16] = 8'hC4;
      flash_mem[17] = 8'hA9;
      flash_mem[18] = 8'hB8;
      flash_mem[19] = 8'hD5;
      for (int i = 0; i < 64; i++) ram_mem[i] = 32'd0;

      test_reset();
      test_wait_ready();
      test_startup_delay();
      test_cmd_addr();
      test_busy_stall();
      test_reset_mid_read();
      test_full_run();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
